// File: rtl/vga_timing_mixer.sv
// VGA raster generator with a two-stage output pipeline that composites one
// registered overlay source over a background colour inside the active area.
module vga_timing_mixer #(
  parameter int          H_VISIBLE = 800,
  parameter int          H_FRONT   = 40,
  parameter int          H_SYNC    = 128,
  parameter int          H_BACK    = 88,
  parameter int          V_VISIBLE = 600,
  parameter int          V_FRONT   = 1,
  parameter int          V_SYNC    = 4,
  parameter int          V_BACK    = 23,
  parameter bit          HS_POL    = 1'b1,
  parameter bit          VS_POL    = 1'b1,
  parameter logic [23:0] COLOUR_BG = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [10:0] vga_h,
  output logic [10:0] vga_v,
  input  logic [23:0] overlay_pixel,
  input  logic        overlay_on,
  output logic [23:0] vga_rgb,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_start
);

  localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] V_LAST   = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= 11'd0;
      v_cnt <= 11'd0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= 11'd0;
      v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign vga_h = h_cnt;
  assign vga_v = v_cnt;

  logic de0, hs0, vs0, fs0;

  assign de0 = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs0 = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs0 = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign fs0 = (h_cnt == 11'd0) && (v_cnt == 11'd0);

  // Overlay contract: no handshake. The overlay sees (vga_h, vga_v) in cycle N
  // and must present overlay_on/overlay_pixel for that position in cycle N+1,
  // which is when the stage-1 decode for the same position is held here.
  logic de_d1, hs_d1, vs_d1, fs_d1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_d1 <= 1'b0;
      hs_d1 <= 1'b0;
      vs_d1 <= 1'b0;
      fs_d1 <= 1'b0;
    end else begin
      de_d1 <= de0;
      hs_d1 <= hs0;
      vs_d1 <= vs0;
      fs_d1 <= fs0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_rgb     <= 24'h0;
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      vga_de      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_rgb     <= de_d1 ? (overlay_on ? overlay_pixel : COLOUR_BG) : 24'h0;
      vga_hs      <= hs_d1 ? HS_POL : ~HS_POL;
      vga_vs      <= vs_d1 ? VS_POL : ~VS_POL;
      vga_de      <= de_d1;
      frame_start <= fs_d1;
    end
  end

endmodule

// File: tb/tb_vga_timing_mixer.sv
// Bench for vga_timing_mixer on a reduced raster: per-cycle counter checks in
// the driver, pin-level expectations queued and compared by a monitor.
module tb_vga_timing_mixer;

  localparam int          HV = 20, HF = 3, HSW = 5, HB = 4;
  localparam int          VV = 12, VF = 1, VSW = 2, VB = 3;
  localparam bit          HSP = 1'b1;
  localparam bit          VSP = 1'b0;
  localparam logic [23:0] BG = 24'hFFFFFF;
  localparam int          HT = HV + HF + HSW + HB;
  localparam int          VT = VV + VF + VSW + VB;
  localparam int          FRAME = HT * VT;
  localparam logic [27:0] RST_WORD = {24'h0, 1'b0, ~HSP, ~VSP, 1'b0};

  // clock / reset
  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] vga_h, vga_v;
  logic [23:0] overlay_pixel;
  logic        overlay_on;
  logic [23:0] vga_rgb;
  logic        vga_hs, vga_vs, vga_de, frame_start;

  always #5 clk = ~clk;

  vga_timing_mixer #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(HSP), .VS_POL(VSP), .COLOUR_BG(BG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vga_h(vga_h), .vga_v(vga_v),
    .overlay_pixel(overlay_pixel), .overlay_on(overlay_on),
    .vga_rgb(vga_rgb), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_de(vga_de), .frame_start(frame_start)
  );

  // scoreboard state
  logic [27:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          k = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h required %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [27:0] exp_word(input int h, input int v,
                                           input logic on, input logic [23:0] pix);
    logic de, hs, vs, fs;
    logic [23:0] rgb;
    de  = (h < HV) && (v < VV);
    hs  = (h >= HV + HF) && (h < HV + HF + HSW);
    vs  = (v >= VV + VF) && (v < VV + VF + VSW);
    fs  = (h == 0) && (v == 0);
    rgb = de ? (on ? pix : BG) : 24'h0;
    return {rgb, de, hs ? HSP : ~HSP, vs ? VSP : ~VSP, fs};
  endfunction

  // Directed overlay pattern: {on, pixel} for a raster position.
  function automatic logic [24:0] stub(input int h, input int v);
    if (v == 2 && h >= 4 && h <= 9)      return {1'b1, 24'hFF0000};
    if (v == 3 && h >= HV && h < HV + 8) return {1'b1, 24'h123456};
    if (v == VV + 1 && h < 8)            return {1'b1, 24'h123456};
    if (v == 5 && h < HV)                return {1'b1, 8'h00, 8'hA0, 8'(h)};
    return {1'b0, 24'hABCDEF};
  endfunction

  // driver tasks
  task automatic step();
    int h, v, ph, pv;
    logic [24:0] s;
    @(posedge clk);
    #1;
    k++;
    h  = k % HT;
    v  = (k / HT) % VT;
    check("vga_h", 32'(vga_h), 32'(h));
    check("vga_v", 32'(vga_v), 32'(v));
    ph = (k - 1) % HT;
    pv = ((k - 1) / HT) % VT;
    s  = stub(ph, pv);
    overlay_on    = s[24];
    overlay_pixel = s[23:0];
    exp_q.push_back(exp_word(ph, pv, s[24], s[23:0]));
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_h"}, 32'(vga_h), 32'd0);
    check({tag, "_v"}, 32'(vga_v), 32'd0);
    check({tag, "_pins"}, 32'({vga_rgb, vga_de, vga_hs, vga_vs, frame_start}), 32'(RST_WORD));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3;
    exp_q.delete();
    exp_q.push_back(RST_WORD);
    k       = 0;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    check("release_h", 32'(vga_h), 32'd0);
  endtask

  // monitor
  initial begin
    logic [27:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && k >= 1) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pins", 32'({vga_rgb, vga_de, vga_hs, vga_vs, frame_start}), 32'(e));
        end
      end
    end
  end

  initial begin
    int guard;
    reset_n       = 1'b0;
    overlay_on    = 1'b0;
    overlay_pixel = 24'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rst("reset");
    release_reset();
    repeat (2 * FRAME + 40) step();

    guard = 0;
    while (!((k % HT) == 10 && ((k / HT) % VT) == 6) && guard < FRAME) begin
      step();
      guard++;
    end
    check("mid_reset_reached", 32'(guard < FRAME), 32'd1);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_rst("mid_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rst("reset_hold");
    release_reset();
    repeat (FRAME + 40) step();

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
